// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_pkg
// Description : Shared ALU opcode encodings, divider state type and a
//               helper that recognises the four divide/remainder opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

  localparam int ALU_OP_W = 5;
  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam alu_op_t ALU_ADD    = 5'b00000;
  localparam alu_op_t ALU_SUB    = 5'b00001;
  localparam alu_op_t ALU_SLL    = 5'b00010;
  localparam alu_op_t ALU_SLT    = 5'b00011;
  localparam alu_op_t ALU_SLTU   = 5'b00100;
  localparam alu_op_t ALU_XOR    = 5'b00101;
  localparam alu_op_t ALU_SRL    = 5'b00110;
  localparam alu_op_t ALU_SRA    = 5'b00111;
  localparam alu_op_t ALU_OR     = 5'b01000;
  localparam alu_op_t ALU_AND    = 5'b01001;
  localparam alu_op_t ALU_MUL    = 5'b01010;
  localparam alu_op_t ALU_MULH   = 5'b01011;
  localparam alu_op_t ALU_MULHSU = 5'b01100;
  localparam alu_op_t ALU_DIVU   = 5'b01101;
  localparam alu_op_t ALU_DIVS   = 5'b01110;
  localparam alu_op_t ALU_REMU   = 5'b01111;
  localparam alu_op_t ALU_REMS   = 5'b10000;
  localparam alu_op_t ALU_MULHU  = 5'b10001;
  localparam alu_op_t ALU_PASSB  = 5'b10010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  function automatic logic is_div_op(alu_op_t op);
    return (op == ALU_DIVU) || (op == ALU_DIVS) ||
           (op == ALU_REMU) || (op == ALU_REMS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_div_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : md_div_unit_if
// Description : Request/response handshake bundle of the iterative divider.
//               master = pipeline side, slave = divider side.
// Revision    : 1.0 - initial release
// ============================================================================
interface md_div_unit_if #(
  parameter int XLEN = 32,
  parameter int OP_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] alu_op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, alu_op, a, b, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, alu_op, a, b, out_ready,
    output in_ready, out_valid, result
  );
endinterface
`default_nettype wire

// File: rtl/div_sign_fix.sv
`default_nettype none
// ============================================================================
// Module      : div_sign_fix
// Description : Conditional two's-complement negate. Used as |x| on the
//               operands (i_neg = sign bit) and as sign restore on results.
// Revision    : 1.0 - initial release
// ============================================================================
module div_sign_fix #(
  parameter int XLEN = 32
) (
  input  wire logic [XLEN-1:0] i_val,
  input  wire logic            i_neg,
  output logic      [XLEN-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + XLEN'(1)) : i_val;

endmodule
`default_nettype wire

// File: rtl/md_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_div_unit
// Description : Iterative radix-2 restoring divider for divu/divs/remu/rems.
//               Normal ops take XLEN+1 edges from accept to out_valid;
//               divide-by-zero, signed overflow, non-divide opcodes and
//               (optionally) cache hits take 1 edge.
//               Optional macro DIV_RESULT_CACHE_EN adds a one-entry result
//               cache keyed on (a, b, signedness).
// Revision    : 1.0 - initial release
// ============================================================================
module md_div_unit
  import md_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 5
) (
  input  wire logic   clk,
  input  wire logic   rst,
  input  wire logic   kill_i,
  md_div_unit_if.slave s_if
);

  localparam int              CW     = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] c_xmin = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t r_state, w_next;

  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rem;       // partial remainder (always < divisor)
  logic [XLEN-1:0] r_quo;       // dividend shifting out, quotient shifting in
  logic [XLEN-1:0] r_div;       // |divisor|
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_want_rem;
  logic            r_special;
  logic [XLEN-1:0] r_spec_res;
  logic [XLEN-1:0] r_result;

  logic [OP_W-1:0] w_op;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic            w_accept;
  logic            w_is_div;
  logic            w_signed;
  logic            w_want_rem;
  logic            w_b_zero;
  logic            w_ovf;
  logic            w_hit;
  logic            w_special;
  logic [XLEN-1:0] w_spec_res;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_trial;
  logic            w_qbit;

  assign w_op       = s_if.alu_op;
  assign w_a        = s_if.a;
  assign w_b        = s_if.b;
  assign w_accept   = s_if.in_valid & (r_state == IDLE) & ~kill_i;
  assign w_is_div   = is_div_op(5'(w_op));
  assign w_signed   = (w_op == OP_W'(ALU_DIVS)) | (w_op == OP_W'(ALU_REMS));
  assign w_want_rem = (w_op == OP_W'(ALU_REMU)) | (w_op == OP_W'(ALU_REMS));
  assign w_b_zero   = (w_b == '0);
  assign w_ovf      = w_signed & (w_a == c_xmin) & (w_b == '1);
  assign w_special  = ~w_is_div | w_b_zero | w_ovf | w_hit;

  // One restoring step on the XLEN+1-bit shifted remainder
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_trial = w_shift - {1'b0, r_div};
  assign w_qbit  = ~w_trial[XLEN];

  div_sign_fix #(.XLEN(XLEN)) u_abs_a (
    .i_val (w_a),
    .i_neg (w_signed & w_a[XLEN-1]),
    .o_val (w_a_abs)
  );

  div_sign_fix #(.XLEN(XLEN)) u_abs_b (
    .i_val (w_b),
    .i_neg (w_signed & w_b[XLEN-1]),
    .o_val (w_b_abs)
  );

  div_sign_fix #(.XLEN(XLEN)) u_fix_q (
    .i_val (r_quo),
    .i_neg (r_neg_q),
    .o_val (w_q_fix)
  );

  div_sign_fix #(.XLEN(XLEN)) u_fix_r (
    .i_val (r_rem),
    .i_neg (r_neg_r),
    .o_val (w_r_fix)
  );

`ifdef DIV_RESULT_CACHE_EN
  logic            r_c_valid;
  logic [XLEN-1:0] r_c_a;
  logic [XLEN-1:0] r_c_b;
  logic            r_c_signed;
  logic [XLEN-1:0] r_c_q;
  logic [XLEN-1:0] r_c_r;
  logic [XLEN-1:0] r_a_raw;
  logic [XLEN-1:0] r_b_raw;
  logic            r_signed;

  assign w_hit = r_c_valid & w_is_div & (w_a == r_c_a) & (w_b == r_c_b) &
                 (w_signed == r_c_signed);

  // Cache entry: filled when a normal op finishes, dropped on reset/kill
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_c_valid  <= 1'b0;
      r_c_a      <= '0;
      r_c_b      <= '0;
      r_c_signed <= 1'b0;
      r_c_q      <= '0;
      r_c_r      <= '0;
      r_a_raw    <= '0;
      r_b_raw    <= '0;
      r_signed   <= 1'b0;
    end else if (kill_i) begin
      r_c_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a_raw  <= w_a;
        r_b_raw  <= w_b;
        r_signed <= w_signed;
      end
      if ((r_state == FIX) && !r_special) begin
        r_c_valid  <= 1'b1;
        r_c_a      <= r_a_raw;
        r_c_b      <= r_b_raw;
        r_c_signed <= r_signed;
        r_c_q      <= w_q_fix;
        r_c_r      <= w_r_fix;
      end
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  // Short-path result: RISC-V corner cases, non-divide opcodes, cache hits
  always_comb begin
    w_spec_res = '0;
    if (!w_is_div) begin
      w_spec_res = '0;
    end else if (w_b_zero) begin
      w_spec_res = w_want_rem ? w_a : '1;
    end else if (w_ovf) begin
      w_spec_res = w_want_rem ? '0 : c_xmin;
`ifdef DIV_RESULT_CACHE_EN
    end else if (w_hit) begin
      w_spec_res = w_want_rem ? r_c_r : r_c_q;
`endif
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; kill overrides every transition
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = w_special ? FIX : RUN;
      RUN:  if (r_cnt == CW'(1)) w_next = FIX;
      FIX:  w_next = DONE;
      DONE: if (s_if.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (kill_i) w_next = IDLE;
  end

  // Datapath: operand capture, iteration and result registration
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_div      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_want_rem <= 1'b0;
      r_special  <= 1'b0;
      r_spec_res <= '0;
      r_result   <= '0;
    end else if (kill_i) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_quo      <= w_a_abs;
            r_div      <= w_b_abs;
            r_rem      <= '0;
            r_cnt      <= w_special ? '0 : CW'(XLEN);
            r_neg_q    <= w_signed & (w_a[XLEN-1] ^ w_b[XLEN-1]);
            r_neg_r    <= w_signed & w_a[XLEN-1];
            r_want_rem <= w_want_rem;
            r_special  <= w_special;
            r_spec_res <= w_spec_res;
          end
        end
        RUN: begin
          r_rem <= w_qbit ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
          r_quo <= {r_quo[XLEN-2:0], w_qbit};
          r_cnt <= r_cnt - CW'(1);
        end
        FIX: begin
          r_result <= r_special  ? r_spec_res :
                      r_want_rem ? w_r_fix    : w_q_fix;
        end
        default: ;
      endcase
    end
  end

  assign s_if.in_ready  = (r_state == IDLE);
  assign s_if.out_valid = (r_state == DONE);
  assign s_if.result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_md_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_div_unit
// Description : Self-checking bench for md_div_unit: directed corner cases,
//               back-pressure, kill, mid-operation reset and random ops
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_div_unit;
  import md_pkg::*;

  localparam int XLEN = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic kill = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic        m_c_valid = 1'b0;
  logic [31:0] m_c_a, m_c_b;
  logic        m_c_s;

  always #5 clk = ~clk;

  md_div_unit_if #(.XLEN(XLEN), .OP_W(5)) bus ();

  md_div_unit #(.XLEN(XLEN), .OP_W(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .kill_i (kill),
    .s_if   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic is_signed_op(alu_op_t op);
    return (op == ALU_DIVS) || (op == ALU_REMS);
  endfunction

  // RISC-V M-extension semantics in plain arithmetic
  function automatic logic [31:0] ref_result(alu_op_t op, logic [31:0] a, logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_REMU: return (b == 0) ? a : a % b;
      ALU_DIVS: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
        return 32'(sa / sb);
      end
      ALU_REMS: begin
        if (b == 0) return a;
        if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic int exp_latency(alu_op_t op, logic [31:0] a, logic [31:0] b);
    if (!((op == ALU_DIVU) || (op == ALU_DIVS) || (op == ALU_REMU) || (op == ALU_REMS))) return 1;
    if (b == 0) return 1;
    if (is_signed_op(op) && a == MINV && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_RESULT_CACHE_EN
    if (m_c_valid && m_c_a == a && m_c_b == b && m_c_s == is_signed_op(op)) return 1;
`endif
    return XLEN + 1;
  endfunction

  task automatic start_op(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.alu_op    = op;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Issue one op, measure latency, hold back-pressure, then release
  task automatic run_op(input string tag, input alu_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    int          lat;
    int          elat;
    logic [31:0] exp;
    elat = exp_latency(op, a, b);
    exp  = ref_result(op, a, b);
    @(negedge clk);
    check({tag, "/rdy"}, 32'(bus.in_ready), 32'd1);
    start_op(op, a, b);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "/lat"}, 32'(lat), 32'(elat));
    check({tag, "/res"}, bus.result, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "/hold"}, {bus.result, 30'd0, bus.out_valid, bus.in_ready} == {exp, 32'd2} ? 32'd1 : 32'd0, 32'd1);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "/rel"}, {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
    bus.out_ready = 1'b0;
    if (elat == XLEN + 1) begin
      m_c_valid = 1'b1;
      m_c_a     = a;
      m_c_b     = b;
      m_c_s     = is_signed_op(op);
    end
  endtask

  initial begin
    int      seen;
    alu_op_t rop;
    logic [31:0] ra, rb;
    alu_op_t ops[4] = '{ALU_DIVU, ALU_DIVS, ALU_REMU, ALU_REMS};

    bus.in_valid  = 1'b0;
    bus.alu_op    = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset", {bus.result, 30'd0, bus.out_valid, bus.in_ready}, 64'h0000_0000_0000_0001);
    @(negedge clk);
    rst = 1'b1;

    run_op("divu100_7", ALU_DIVU, 32'd100, 32'd7, 0);
    run_op("remu100_7", ALU_REMU, 32'd100, 32'd7, 0);
    run_op("divs-7_2",  ALU_DIVS, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("rems-7_2",  ALU_REMS, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu_b0",   ALU_DIVU, 32'h1234, 32'd0, 0);
    run_op("remu_b0",   ALU_REMU, 32'h1234, 32'd0, 0);
    run_op("divs_ovf",  ALU_DIVS, MINV, 32'hFFFF_FFFF, 0);
    run_op("rems_ovf",  ALU_REMS, MINV, 32'hFFFF_FFFF, 0);
    run_op("badop",     ALU_ADD,  32'd5, 32'd3, 0);
    run_op("bp_divu",   ALU_DIVU, 32'd1000, 32'd9, 5);
    run_op("remu1000",  ALU_REMU, 32'd1000, 32'd9, 0);

    // kill in the middle of an iteration
    start_op(ALU_DIVU, 32'd12345, 32'd17);
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    m_c_valid = 1'b0;
    check("kill_idle", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
    @(negedge clk);
    kill = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("kill_noval", 32'(seen), 32'd0);

    // a request presented together with kill is ignored
    @(negedge clk);
    kill          = 1'b1;
    bus.in_valid  = 1'b1;
    bus.alu_op    = ALU_DIVU;
    bus.a         = 32'd50;
    bus.b         = 32'd5;
    @(negedge clk);
    kill         = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("kill_noacc", 32'(bus.in_ready), 32'd1);

    // cache pair separated by a kill must run the full latency twice
    run_op("c_divu", ALU_DIVU, 32'd1000, 32'd9, 0);
    @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    m_c_valid = 1'b0;
    run_op("c_remu", ALU_REMU, 32'd1000, 32'd9, 0);

    // reset in the middle of RUN
    start_op(ALU_DIVS, 32'hFFFF_0000, 32'd3);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_run", {bus.result, 30'd0, bus.out_valid, bus.in_ready}, 64'h0000_0000_0000_0001);
    @(negedge clk);
    rst = 1'b1;
    m_c_valid = 1'b0;

    for (int n = 0; n < 30; n++) begin
      rop = ops[$urandom_range(0, 3)];
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = MINV; rb = 32'hFFFF_FFFF; end
        2: rop = ALU_XOR;
        3: rb = rb >> $urandom_range(1, 30);
        default: ;
      endcase
      run_op($sformatf("rnd%0d", n), rop, ra, rb, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
